lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit for the core's MEM stage, between the EX-stage request and the `DataMem` word-addressed data memory. It handles one request at a time from EX over a valid/ready handshake. It converts byte addresses to word indices and performs sub-word stores (SB/SH) as read-modify-write sequences of full-word writes. It sign- or zero-extends load data and returns one response per request to WB.

## Interface
Parameters:
- `DEPTH`, default 16: number of 32-bit words in `DataMem`.
- `AW`, default `$clog2(DEPTH)`: word-index width. Derived from `DEPTH`; never overridden.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: EX request present.
- `req_ready` out 1: block can accept a request.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_rd` in 5: load destination register.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rd` out 5: destination register; 0 for stores and errors.
- `rsp_data` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: request was misaligned or had an illegal funct3.
- `dm_rd_addr` out AW: `DataMem` read word index.
- `dm_wr_addr` out AW: `DataMem` write word index.
- `dm_wr_din` out 32: `DataMem` write word.
- `dm_we` out 1: `DataMem` write enable.
- `dm_wr_strb` out 3: always 3'b010 (full word).
- `dm_rd_dout` in 32: `DataMem` read data, valid one cycle after `dm_rd_addr`.

## Operation
- Word index is `req_addr[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH`.
- Lanes are little-endian: lane k is bits `8k+7:8k`.
- States are IDLE, LD_ADDR, LD_DATA, RMW_ADDR, RMW_MERGE, ST_WRITE, RESP.
- `req_ready` = (state == IDLE) && !rst.
- A request is accepted when `req_valid && req_ready`; its fields are registered on acceptance.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned accesses: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
- State transitions:
  - Illegal or misaligned request: IDLE→RESP with `rsp_err`=1. No `DataMem` access.
  - Load: IDLE→LD_ADDR→LD_DATA→RESP. In LD_DATA, `dm_rd_dout` is extracted and extended and `rsp_data` is registered.
  - SW: IDLE→ST_WRITE→RESP.
  - SB/SH: IDLE→RMW_ADDR→RMW_MERGE→ST_WRITE→RESP.
    - In RMW_MERGE, the addressed lane(s) of `dm_rd_dout` are replaced by `req_wdata[7:0]` or `req_wdata[15:0]`, and the merged word is registered.
- In RESP: `rsp_valid`=1 for that cycle only, then the state returns to IDLE. WB never back-pressures.
- `dm_we` = (state == ST_WRITE) && !rst.
- All `dm_*` outputs are driven from registers or state only; there is no combinational path from `req_*`.

## Timing
- Reset values: state IDLE; `rsp_valid`, `rsp_err`, `dm_we` = 0; `rsp_data`, `rsp_rd`, `dm_rd_addr`, `dm_wr_addr`, `dm_wr_din` = 0; `dm_wr_strb` = 3'b010.
- `req_ready`=0 while `rst`=1.
- Latency, counted from the accept cycle 0 to the `rsp_valid` cycle:
  - Error: 1.
  - SW: 2, with `dm_we` in cycle 1.
  - Load: 3, with `dm_rd_addr` valid from cycle 1 and data sampled in cycle 2.
  - SB/SH: 4, with `dm_we` in cycle 3.
- `req_ready` is 0 from cycle 1 up to and including the RESP cycle. It is 1 again in the cycle after RESP.
- At most one request is outstanding, so there are no load/store ordering hazards.
- Reset mid-operation aborts the sequence. No `DataMem` write is issued if `rst` is high in the ST_WRITE cycle, and no `rsp_valid` is produced.

## Structure
- Shared package `riscv_mem_pkg` holds:
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - the state enum `lsu_state_t`;
  - `DM_STRB_WORD` = 3'b010.
- One combinational sub-module, `lsu_load_align`: takes a word, `addr[1:0]` and funct3, and returns the extended result. It is reused by RMW_MERGE lane selection.

## Test plan
- **Reset and handshake:** `rst`=1 for 2 cycles → `req_ready`=0, `rsp_valid`=0, `dm_we`=0. Release → `req_ready`=1. With `req_valid` held high, `req_ready` drops in cycle 1.
- **SW:** addr 0x0, data F0F00F0F → cycle 1: `dm_we`=1, `dm_wr_addr`=0, `dm_wr_din`=F0F00F0F, `dm_wr_strb`=010. Cycle 2: `rsp_valid`=1, `rsp_err`=0.
- **Loads on that word, each with `rsp_valid` at cycle 3:**
  - LB 0x3 → FFFFFFF0.
  - LBU 0x1 → 0000000F.
  - LH 0x2 → FFFFF0F0.
  - LHU 0x2 → 0000F0F0.
  - LW 0x40 → F0F00F0F (wrap to word 0).
- **SB:** 0x1, data 0xAA → `dm_we` in cycle 3 with `dm_wr_din`=F0F0AA0F, then LW 0x0 → F0F0AA0F. SH 0x2, data 0x1234 → LW 0x0 → 1234AA0F.
- **Errors:** LW 0x2, SH 0x3, load funct3 011 → cycle 1: `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0, `rsp_rd`=0; `dm_we` never asserted.
- **Reset mid-RMW:** assert `rst` during RMW_MERGE of SB 0x0 → no `dm_we` and no `rsp_valid`. After release, LW 0x0 returns the previous word and `req_ready`=1.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: funct3 encodings,
// the LSU state type, the DataMem strobe code and request legality check.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] DM_STRB_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    LD_ADDR,
    LD_DATA,
    RMW_ADDR,
    RMW_MERGE,
    ST_WRITE,
    RESP
  } lsu_state_t;

  // A request is rejected when its funct3 is not a legal encoding for its
  // direction, or when a halfword/word access is not naturally aligned.
  function automatic logic reqError(input logic isStore, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic illegal;
    logic misaligned;
    if (isStore) begin
      illegal = !(f3 inside {F3_B, F3_H, F3_W});
    end else begin
      illegal = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane extractor: picks the byte/halfword addressed by off_i out of a
// little-endian word and sign- or zero-extends it according to funct3_i.
module lsu_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Select the addressed lane, then extend it to 32 bits.
  always_comb begin
    laneByte = word_i[{off_i, 3'b000} +: 8];
    laneHalf = word_i[{off_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    data_o = {{24{laneByte[7]}}, laneByte};
      F3_H:    data_o = {{16{laneHalf[15]}}, laneHalf};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {24'd0, laneByte};
      F3_HU:   data_o = {16'd0, laneHalf};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit. Accepts one EX request at a time, talks to a
// word-addressed DataMem with one-cycle read latency, implements SB/SH as a
// read-modify-write of a full word, and returns one response pulse to WB.
module lsu_mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_is_store,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [4:0]    req_rd,
  output logic          rsp_valid,
  output logic [4:0]    rsp_rd,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] dm_rd_addr,
  output logic [AW-1:0] dm_wr_addr,
  output logic [31:0]   dm_wr_din,
  output logic          dm_we,
  output logic [2:0]    dm_wr_strb,
  input  logic [31:0]   dm_rd_dout
);

  lsu_state_t state_q, state_d;

  logic          isStore_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [15:0]   wdata_q;
  logic          rspErr_q;
  logic [4:0]    rspRd_q;
  logic [31:0]   rspData_q;
  logic [AW-1:0] rdAddr_q;
  logic [AW-1:0] wrAddr_q;
  logic [31:0]   wrDin_q;

  logic          accept;
  logic          reqErr;
  logic [AW-1:0] reqIdx;
  logic [2:0]    alignF3;
  logic [31:0]   alignData;
  logic [31:0]   newLane;
  logic [31:0]   laneDiff;
  logic [31:0]   mergedWord;
  logic          unusedAddrBits;

  assign accept         = req_valid && req_ready;
  assign reqErr         = reqError(req_is_store, req_funct3, req_addr[1:0]);
  assign reqIdx         = req_addr[AW+1:2];
  assign unusedAddrBits = ^req_addr[31:AW+2];

  // Stores reuse the aligner in unsigned mode to read back the old lane
  // contents; XOR-ing old^new into place replaces exactly those lanes.
  assign alignF3    = isStore_q ? {1'b1, funct3_q[1:0]} : funct3_q;
  assign newLane    = (funct3_q == F3_B) ? {24'd0, wdata_q[7:0]} : {16'd0, wdata_q};
  assign laneDiff   = (alignData ^ newLane) << {off_q, 3'b000};
  assign mergedWord = dm_rd_dout ^ laneDiff;

  lsu_load_align u_align (
    .word_i   (dm_rd_dout),
    .off_i    (off_q),
    .funct3_i (alignF3),
    .data_o   (alignData)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: route each accepted request down its access sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reqErr)                  state_d = RESP;
          else if (!req_is_store)      state_d = LD_ADDR;
          else if (req_funct3 == F3_W) state_d = ST_WRITE;
          else                         state_d = RMW_ADDR;
        end
      end
      LD_ADDR:   state_d = LD_DATA;
      LD_DATA:   state_d = RESP;
      RMW_ADDR:  state_d = RMW_MERGE;
      RMW_MERGE: state_d = ST_WRITE;
      ST_WRITE:  state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Handshake, response pulse and write enable are decoded from the state.
  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
    rsp_valid = (state_q == RESP) && !rst;
    dm_we     = (state_q == ST_WRITE) && !rst;
  end

  // Datapath: capture the request, then fill in load data or merged word.
  always_ff @(posedge clk) begin
    if (rst) begin
      isStore_q <= 1'b0;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      wdata_q   <= 16'd0;
      rspErr_q  <= 1'b0;
      rspRd_q   <= 5'd0;
      rspData_q <= 32'd0;
      rdAddr_q  <= '0;
      wrAddr_q  <= '0;
      wrDin_q   <= 32'd0;
    end else begin
      if (accept) begin
        isStore_q <= req_is_store;
        funct3_q  <= req_funct3;
        off_q     <= req_addr[1:0];
        wdata_q   <= req_wdata[15:0];
        rspErr_q  <= reqErr;
        rspRd_q   <= (!req_is_store && !reqErr) ? req_rd : 5'd0;
        rspData_q <= 32'd0;
        rdAddr_q  <= reqIdx;
        wrAddr_q  <= reqIdx;
        wrDin_q   <= req_wdata;
      end
      if (state_q == LD_DATA)   rspData_q <= alignData;
      if (state_q == RMW_MERGE) wrDin_q   <= mergedWord;
    end
  end

  assign rsp_rd     = rspRd_q;
  assign rsp_data   = rspData_q;
  assign rsp_err    = rspErr_q;
  assign dm_rd_addr = rdAddr_q;
  assign dm_wr_addr = wrAddr_q;
  assign dm_wr_din  = wrDin_q;
  assign dm_wr_strb = DM_STRB_WORD;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: a byte-level reference memory and
// request model predict every response and DataMem write, and a per-cycle
// compare process checks the DUT against that prediction.
module tb_lsu_mem_stage;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_is_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [4:0]    req_rd;
  logic          rsp_valid;
  logic [4:0]    rsp_rd;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic [AW-1:0] dm_rd_addr;
  logic [AW-1:0] dm_wr_addr;
  logic [31:0]   dm_wr_din;
  logic          dm_we;
  logic [2:0]    dm_wr_strb;
  logic [31:0]   dm_rd_dout;

  lsu_mem_stage #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .rsp_valid    (rsp_valid),
    .rsp_rd       (rsp_rd),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .dm_rd_addr   (dm_rd_addr),
    .dm_wr_addr   (dm_wr_addr),
    .dm_wr_din    (dm_wr_din),
    .dm_we        (dm_we),
    .dm_wr_strb   (dm_wr_strb),
    .dm_rd_dout   (dm_rd_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMem stand-in: registered read, write on dm_we.
  logic [31:0] memW [DEPTH];
  always @(posedge clk) begin
    if (dm_we) memW[dm_wr_addr] <= dm_wr_din;
    dm_rd_dout <= memW[dm_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: byte image of memory and the outstanding expectation.
  logic [7:0]  refMem [4*DEPTH];
  int          acceptCyc = -100;
  int          expRspCyc = -1;
  int          expWeCyc  = -1;
  int          expIdx    = 0;
  logic [31:0] expData   = 0;
  logic [4:0]  expRd     = 0;
  logic        expErr    = 0;
  logic [31:0] expWord   = 0;
  bit          litValid  = 0;
  logic [31:0] litData   = 0;
  bit          checkRdAddr = 0;
  bit          started   = 0;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one request, wait for acceptance, then predict its outcome from
  // the byte image: legality, latency, response value and written word.
  task automatic applyStimulus(input bit isStore, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd,
                               input bit hasLit, input logic [31:0] lit);
    int idx, off, size, lat;
    bit legal, sgn, err, accepted;
    logic [31:0] val;
    accepted = 0;
    for (int t = 0; t < 30 && !accepted; t++) begin
      @(posedge clk); #1;
      req_valid    = 1'b1;
      req_is_store = isStore;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wdata;
      req_rd       = rd;
      if (req_ready === 1'b1) accepted = 1;
    end
    if (!accepted) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    idx  = int'((addr >> 2) % DEPTH);
    off  = int'(addr % 4);
    legal = 1; sgn = 0; size = 0;
    if (isStore) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: legal = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: legal = 0;
      endcase
    end
    if (!legal) err = 1;
    else        err = (off % size) != 0;
    val = 0;
    if (!err && !isStore) begin
      for (int i = 0; i < size; i++) val |= 32'(refMem[idx*4+off+i]) << (8*i);
      if (sgn && val[8*size-1]) val |= 32'hFFFF_FFFF << (8*size);
    end
    expWord = {refMem[idx*4+3], refMem[idx*4+2], refMem[idx*4+1], refMem[idx*4]};
    if (!err && isStore) begin
      for (int i = 0; i < size; i++) expWord[8*(off+i) +: 8] = wdata[8*i +: 8];
    end
    lat = err ? 1 : (!isStore ? 3 : (size == 4 ? 2 : 4));
    acceptCyc   = cyc;
    expRspCyc   = cyc + lat;
    expWeCyc    = (isStore && !err) ? cyc + lat - 1 : -1;
    expData     = (isStore || err) ? 32'd0 : val;
    expRd       = (isStore || err) ? 5'd0 : rd;
    expErr      = err;
    expIdx      = idx;
    litValid    = hasLit;
    litData     = lit;
    checkRdAddr = !err && !(isStore && size == 4);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Per-cycle comparison of every DUT output that matters in this cycle.
  always @(negedge clk) begin
    bit busy, expValid, expWe;
    if (started) begin
      busy     = (cyc > acceptCyc) && (cyc <= expRspCyc);
      expValid = (cyc == expRspCyc) && !rst;
      expWe    = (cyc == expWeCyc) && !rst;
      checkOutput("req_ready", 32'(req_ready), 32'(!rst && !busy));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(expValid));
      checkOutput("dm_we", 32'(dm_we), 32'(expWe));
      if (expValid) begin
        checkOutput("rsp_data", rsp_data, expData);
        checkOutput("rsp_rd", 32'(rsp_rd), 32'(expRd));
        checkOutput("rsp_err", 32'(rsp_err), 32'(expErr));
        if (litValid) checkOutput("rsp_data_literal", rsp_data, litData);
      end
      if (expWe) begin
        checkOutput("dm_wr_addr", 32'(dm_wr_addr), 32'(expIdx));
        checkOutput("dm_wr_din", dm_wr_din, expWord);
        checkOutput("dm_wr_strb", 32'(dm_wr_strb), 32'd2);
        for (int i = 0; i < 4; i++) refMem[expIdx*4+i] = expWord[8*i +: 8];
      end
      if (checkRdAddr && (cyc == acceptCyc + 1))
        checkOutput("dm_rd_addr", 32'(dm_rd_addr), 32'(expIdx));
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    for (int i = 0; i < DEPTH; i++) memW[i] = 32'd0;
    for (int i = 0; i < 4*DEPTH; i++) refMem[i] = 8'd0;

    @(posedge clk); #1;
    started = 1;
    @(negedge clk);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_rsp_rd", 32'(rsp_rd), 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_dm_rd_addr", 32'(dm_rd_addr), 32'd0);
    checkOutput("reset_dm_wr_addr", 32'(dm_wr_addr), 32'd0);
    checkOutput("reset_dm_wr_din", dm_wr_din, 32'd0);
    checkOutput("reset_dm_wr_strb", 32'(dm_wr_strb), 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;

    // SW then loads of every width and extension on that word.
    applyStimulus(1, 3'b010, 32'h0000_0000, 32'hF0F0_0F0F, 5'd7, 1, 32'h0000_0000);
    applyStimulus(0, 3'b000, 32'h0000_0003, 32'h0, 5'd1, 1, 32'hFFFF_FFF0);
    applyStimulus(0, 3'b100, 32'h0000_0001, 32'h0, 5'd2, 1, 32'h0000_000F);
    applyStimulus(0, 3'b001, 32'h0000_0002, 32'h0, 5'd3, 1, 32'hFFFF_F0F0);
    applyStimulus(0, 3'b101, 32'h0000_0002, 32'h0, 5'd4, 1, 32'h0000_F0F0);
    applyStimulus(0, 3'b010, 32'h0000_0040, 32'h0, 5'd5, 1, 32'hF0F0_0F0F);

    // Sub-word stores via read-modify-write, upper data bits must be ignored.
    applyStimulus(1, 3'b000, 32'h0000_0001, 32'hFFFF_FFAA, 5'd0, 1, 32'h0);
    applyStimulus(0, 3'b010, 32'h0000_0000, 32'h0, 5'd6, 1, 32'hF0F0_AA0F);
    applyStimulus(1, 3'b001, 32'h0000_0002, 32'hABCD_1234, 5'd0, 1, 32'h0);
    applyStimulus(0, 3'b010, 32'h0000_0000, 32'h0, 5'd6, 1, 32'h1234_AA0F);

    // Misaligned and illegal requests.
    applyStimulus(0, 3'b010, 32'h0000_0002, 32'h0, 5'd8, 1, 32'h0);
    applyStimulus(1, 3'b001, 32'h0000_0003, 32'h5555_5555, 5'd0, 1, 32'h0);
    applyStimulus(0, 3'b011, 32'h0000_0000, 32'h0, 5'd9, 1, 32'h0);
    applyStimulus(1, 3'b100, 32'h0000_0000, 32'h5555_5555, 5'd0, 1, 32'h0);

    // Top word of memory, sign boundaries.
    applyStimulus(1, 3'b010, 32'h0000_003C, 32'h8001_7FFF, 5'd0, 1, 32'h0);
    applyStimulus(0, 3'b001, 32'h0000_003E, 32'h0, 5'd10, 1, 32'hFFFF_8001);
    applyStimulus(0, 3'b101, 32'h0000_003C, 32'h0, 5'd11, 1, 32'h0000_7FFF);
    applyStimulus(0, 3'b000, 32'h0000_003D, 32'h0, 5'd12, 1, 32'h0000_007F);
    applyStimulus(0, 3'b100, 32'h0000_003F, 32'h0, 5'd13, 1, 32'h0000_0080);

    // Reset during RMW_MERGE of an SB: nothing may be written or reported.
    applyStimulus(1, 3'b000, 32'h0000_0000, 32'h0000_0055, 5'd0, 0, 32'h0);
    @(posedge clk); #1;
    rst       = 1'b1;
    expRspCyc = -1;
    expWeCyc  = -1;
    litValid  = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 3'b010, 32'h0000_0000, 32'h0, 5'd14, 1, 32'h1234_AA0F);

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
